fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares one 16-entry synchronous byte FIFO among `NUM_REQ` producers. It grants one producer at a time with a bounded burst and forwards accepted bytes to the FIFO's write port through a registered stage. It tracks FIFO occupancy with its own credit counter, so it never relies on the FIFO's combinational full flag, which is one cycle stale at the registered write stage. It sits directly in front of the FIFO write port, and the FIFO's consumer reports each pop back to it.

## Interface
- `NUM_REQ`, 4: number of producers (2..8).
- `DATA_W`, 8: data width; matches the FIFO.
- `DEPTH`, 16: FIFO storage depth. Usable capacity is `DEPTH-1` (15) because the FIFO reports full at wr_ptr+1 == rd_ptr.
- `MAX_BURST`, 4: maximum consecutive beats per grant (1..15).

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, `NUM_REQ`: producer i has a byte.
- `req_data`, in, `NUM_REQ*DATA_W`: producer i data in slice [i*DATA_W +: DATA_W].
- `req_ready`, out, `NUM_REQ`: producer i byte accepted this cycle when valid & ready.
- `fifo_write_enable`, out, 1: registered write strobe to the FIFO.
- `fifo_data_in`, out, `DATA_W`: registered write data to the FIFO.
- `fifo_pop`, in, 1: FIFO consumer performed a read this cycle (read_enable && !empty).
- `grant_id`, out, 3: index of the current owner; valid when `grant_active` = 1.
- `grant_active`, out, 1: high in state OWN.
- `occupancy`, out, 4: credit counter (accepted beats minus pops), 0..`DEPTH-1`.

## Operation
- States: IDLE and OWN. State register, `grant_id`, `last_owner`, `beat_cnt` and `occupancy` are registered.
- **Arbitration** runs in IDLE, or in OWN when the owner releases this cycle.
  - Scan starts at `last_owner+1` mod `NUM_REQ` and picks the first index with `req_valid` high.
  - On a hit: next state OWN, `grant_id` and `last_owner` take the winner, `beat_cnt` = 0.
  - On no hit: next state IDLE.
- **req_ready[i]** = (state == OWN) & (grant_id == i) & (occupancy < DEPTH-1). It is combinational from registers only and never depends on `req_valid`.
- **Transfer** is valid & ready on the owner.
  - Next cycle: `fifo_write_enable` = 1 and `fifo_data_in` = the owner's data. Otherwise `fifo_write_enable` = 0 and `fifo_data_in` holds its last value.
  - `beat_cnt` increments on each transfer.
- **Release** occurs in OWN when either holds:
  - the owner's `req_valid` is low (no transfer that cycle), or
  - a transfer occurs with `beat_cnt` == MAX_BURST-1.
- On release, arbitration runs the same cycle. The released owner is lowest priority and wins only if no other requester is valid.
- **Credit stall:** `occupancy` == DEPTH-1 drops ready low. The owner keeps its grant and `beat_cnt` freezes. Owner valid low still releases.
- **occupancy** next = occupancy + transfer − (`fifo_pop` & occupancy != 0).
  - Transfer and pop in the same cycle leave it unchanged.
  - A pop at 0 is ignored and the count saturates at 0.
  - A transfer cannot occur at DEPTH-1.

## Timing
- **Reset** (synchronous) sets state IDLE, `grant_active` 0, `grant_id` 0, `last_owner` NUM_REQ-1 (so requester 0 wins first), `beat_cnt` 0, `occupancy` 0, `fifo_write_enable` 0, `fifo_data_in` 0. `req_ready` is all 0.
- **Reset mid-burst:** in-flight and pending bytes are dropped. The FIFO must be reset in the same cycle.
- **First grant:** a valid in IDLE at cycle N gives ready at N+1, and the first write strobe at N+2.
- **Steady state:** one beat per cycle within a grant; acceptance-to-FIFO latency is 1 cycle.
- **Handover:** a burst-limit release with other requesters valid has zero bubble cycles; the next owner is ready in the very next cycle.
- **Credits:** `occupancy` is updated the cycle after the transfer/pop. Ready reflects the updated value on that same cycle.

## Test plan
- **Reset, single producer:** reset, then req_valid=4'b0001 for 20 cycles, data 0x00.. incrementing, with no pops → exactly 15 writes 0x00..0x0E, then ready stays 0 and occupancy = 15. Req 0 keeps its grant, and a fresh burst (beat_cnt from 0) starts after each 4 beats.
- **Round robin:** all four valid continuously, pop every cycle → grant_id sequence 0,1,2,3,0 with 4 beats each, no idle cycles between bursts.
- **Valid drop:** owner 2 drops valid after 2 beats while 3 is valid → next cycle grant_id = 3, beat_cnt = 0, no write strobe in the drop cycle.
- **Full/empty boundary:** occupancy = 15 with owner valid, then one pulse of fifo_pop → ready rises the next cycle, exactly one write follows, occupancy returns to 15. A fifo_pop at occupancy 0 leaves it 0.
- **Simultaneous push and pop:** transfer and fifo_pop in the same cycle at occupancy 7 → occupancy stays 7.
- **Reset mid-burst:** reset asserted on the 2nd beat of owner 1 → next cycle all outputs are at reset values, and the following grant goes to requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a 16-entry byte FIFO.
// Grants one producer at a time for bounded bursts, registers the accepted
// byte onto the FIFO write port, and keeps its own credit count of FIFO
// occupancy. The FIFO's full flag is one cycle stale at the registered stage,
// so the arbiter does not use it.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        fifo_write_enable_o,
  output logic [DATA_W-1:0]           fifo_data_in_o,
  input  logic                        fifo_pop_i,
  output logic [2:0]                  grant_id_o,
  output logic                        grant_active_o,
  output logic [$clog2(DEPTH)-1:0]    occupancy_o
);

  localparam int                 OCC_W     = $clog2(DEPTH);
  // One slot stays empty: the FIFO reports full at wr_ptr+1 == rd_ptr.
  localparam logic [OCC_W-1:0]   OCC_FULL  = OCC_W'(DEPTH - 1);
  localparam logic [3:0]         LAST_BEAT = 4'(MAX_BURST - 1);
  localparam logic [2:0]         RST_LAST  = 3'(NUM_REQ - 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e             state_q, state_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic [2:0]         last_owner_q, last_owner_d;
  logic [3:0]         beat_cnt_q, beat_cnt_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               fwe_q, fwe_d;
  logic [DATA_W-1:0]  fdata_q, fdata_d;

  logic               owner_valid;
  logic [DATA_W-1:0]  owner_data;
  logic               credit_ok;
  logic               own_ok;
  logic               xfer;
  logic               release_now;
  logic               pop_eff;
  logic               hit;
  logic [2:0]         win;
  int                 cand;

  assign credit_ok   = (occ_q != OCC_FULL);
  assign own_ok      = (state_q == OWN) && credit_ok;
  assign xfer        = own_ok && owner_valid;
  assign release_now = (state_q == OWN) &&
                       (!owner_valid || (xfer && (beat_cnt_q == LAST_BEAT)));
  // A pop on an empty count is a consumer error; never wrap below zero.
  assign pop_eff     = fifo_pop_i && (occ_q != '0);

  // Per-producer ready: registered state only, independent of req_valid.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
    assign req_ready_o[g] = own_ok && (grant_id_q == 3'(g));
  end

  // Mux the current owner's valid and data.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        owner_valid = req_valid_i[i];
        owner_data  = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Rotating priority scan starting one past the last owner; the previous
  // owner is visited last, so it only wins when nobody else is asking.
  always_comb begin
    hit  = 1'b0;
    win  = last_owner_q;
    cand = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_owner_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!hit && (cand == i) && req_valid_i[i]) begin
          hit = 1'b1;
          win = 3'(i);
        end
      end
    end
  end

  // Next-state: grant FSM, burst counter, credit counter, write stage.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    occ_d        = occ_q;
    fwe_d        = xfer;
    fdata_d      = xfer ? owner_data : fdata_q;

    if (xfer) beat_cnt_d = beat_cnt_q + 4'd1;

    if (xfer && !pop_eff)      occ_d = occ_q + 1'b1;
    else if (!xfer && pop_eff) occ_d = occ_q - 1'b1;

    // Re-arbitrate in the release cycle itself so handover has no bubble.
    if ((state_q == IDLE) || release_now) begin
      if (hit) begin
        state_d      = OWN;
        grant_id_d   = win;
        last_owner_d = win;
        beat_cnt_d   = 4'd0;
      end else begin
        state_d      = IDLE;
      end
    end
  end

  // State registers with synchronous reset; last_owner starts at the top
  // index so requester 0 is first in line.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      grant_id_q   <= 3'd0;
      last_owner_q <= RST_LAST;
      beat_cnt_q   <= 4'd0;
      occ_q        <= '0;
      fwe_q        <= 1'b0;
      fdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      occ_q        <= occ_d;
      fwe_q        <= fwe_d;
      fdata_q      <= fdata_d;
    end
  end

  assign fifo_write_enable_o = fwe_q;
  assign fifo_data_in_o      = fdata_q;
  assign grant_id_o          = grant_id_q;
  assign grant_active_o      = (state_q == OWN);
  assign occupancy_o         = occ_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter against a cycle-level
// behavioural model built from the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fwe;
  logic [W-1:0]   fdin;
  logic           pop;
  logic [2:0]     gid;
  logic           gact;
  logic [3:0]     occ;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .DEPTH(D), .MAX_BURST(MB)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .fifo_write_enable_o(fwe), .fifo_data_in_o(fdin), .fifo_pop_i(pop),
    .grant_id_o(gid), .grant_active_o(gact), .occupancy_o(occ)
  );

  int total  = 0;
  int passed = 0;

  // Model: owner flag/index, last owner, beats in this grant, credit count,
  // and the expected registered write port.
  bit         m_own;
  int         m_gid, m_last, m_beats, m_occ;
  bit         m_we, m_xfer;
  logic [7:0] m_wd;
  logic [7:0] obs_w[$];

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  function automatic int pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = 0; m_gid = 0; m_last = N - 1; m_beats = 0; m_occ = 0;
    m_we = 0; m_wd = 8'h00; m_xfer = 0;
  endtask

  task automatic model_step();
    bit rel;
    int w;
    m_xfer = m_own && req_valid[m_gid] && (m_occ < D - 1);
    rel    = m_own && (!req_valid[m_gid] || (m_xfer && m_beats == MB - 1));
    m_we   = m_xfer;
    if (m_xfer) m_wd = req_data[m_gid*W +: W];
    m_occ  = m_occ + (m_xfer ? 1 : 0) - ((pop && m_occ != 0) ? 1 : 0);
    if (m_xfer) m_beats++;
    if (!m_own || rel) begin
      w = pick(req_valid, m_last);
      if (w >= 0) begin
        m_own = 1; m_gid = w; m_last = w; m_beats = 0;
      end else m_own = 0;
    end
  endtask

  task automatic check_outputs(string tag);
    logic [N-1:0] er;
    for (int i = 0; i < N; i++) er[i] = m_own && (m_gid == i) && (m_occ < D - 1);
    chk({tag, ":ready"}, 32'(req_ready), 32'(er));
    chk({tag, ":active"}, 32'(gact), 32'(m_own));
    chk({tag, ":gid"}, 32'(gid), 32'(m_gid));
    chk({tag, ":occ"}, 32'(occ), 32'(m_occ));
    chk({tag, ":we"}, 32'(fwe), 32'(m_we));
    chk({tag, ":wdata"}, 32'(fdin), 32'(m_wd));
    if (fwe) obs_w.push_back(fdin);
  endtask

  task automatic cyc(string tag);
    check_outputs(tag);
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; req_valid = '0; pop = 0; req_data = '0;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    obs_w.delete();
  endtask

  initial begin
    logic [7:0] bctr;
    int         nw;

    reset = 1; req_valid = '0; pop = 0; req_data = '0;
    @(posedge clk); #1;
    do_reset();
    chk("rst:ready", 32'(req_ready), 32'h0);
    chk("rst:active", 32'(gact), 32'h0);
    chk("rst:gid", 32'(gid), 32'h0);
    chk("rst:occ", 32'(occ), 32'h0);
    chk("rst:we", 32'(fwe), 32'h0);
    chk("rst:wdata", 32'(fdin), 32'h0);

    // Single producer fills all 15 credits, then stalls with its grant held.
    bctr = 8'h00;
    req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      req_data = {24'h0, bctr};
      if (c == 1) chk("t1:first_ready", 32'(req_ready), 32'h1);
      if (c == 2) chk("t1:first_we", 32'(fwe), 32'h1);
      cyc("t1");
      if (m_xfer) bctr++;
    end
    chk("t1:nwrites", obs_w.size(), 15);
    for (int i = 0; i < obs_w.size() && i < 15; i++) chk("t1:wseq", 32'(obs_w[i]), i);
    chk("t1:occ_full", 32'(occ), 15);
    chk("t1:ready_low", 32'(req_ready), 32'h0);
    chk("t1:hold_grant", 32'({gact, gid}), 32'h8);

    // One pop at full frees exactly one credit, refilled by one write.
    nw = obs_w.size();
    pop = 1;
    cyc("t4");
    pop = 0;
    chk("t4:ready_rise", 32'(req_ready), 32'h1);
    for (int c = 0; c < 4; c++) cyc("t4");
    chk("t4:one_write", obs_w.size() - nw, 1);
    chk("t4:occ_back", 32'(occ), 15);

    // Pop at empty is ignored.
    do_reset();
    pop = 1;
    cyc("t4e"); cyc("t4e");
    pop = 0;
    chk("t4e:occ_zero", 32'(occ), 0);

    // Round robin, every requester valid, consumer pops each cycle.
    do_reset();
    req_valid = 4'b1111; pop = 1;
    req_data = $urandom;
    cyc("rr");
    for (int c = 0; c < 20; c++) begin
      chk("rr:gid_seq", 32'(gid), (c / 4) % 4);
      chk("rr:no_bubble", 32'(req_ready), 32'(1 << ((c / 4) % 4)));
      req_data = $urandom;
      cyc("rr");
    end

    // Owner 2 drops valid after two beats while 3 waits.
    do_reset();
    req_valid = 4'b0100; req_data = $urandom;
    cyc("vd"); cyc("vd"); cyc("vd");
    req_valid = 4'b1000;
    cyc("vd");
    chk("vd:gid3", 32'(gid), 3);
    chk("vd:no_we", 32'(fwe), 0);
    chk("vd:ready3", 32'(req_ready), 32'h8);
    cyc("vd");

    // Transfer and pop together at occupancy 7.
    do_reset();
    req_valid = 4'b0001; req_data = $urandom;
    for (int c = 0; c < 30 && m_occ != 7; c++) cyc("pp");
    chk("pp:at7", 32'(occ), 7);
    pop = 1;
    cyc("pp");
    pop = 0;
    chk("pp:occ7", 32'(occ), 7);
    chk("pp:we", 32'(fwe), 1);

    // Reset during owner 1's second beat.
    do_reset();
    req_valid = 4'b0010; req_data = $urandom;
    cyc("rm"); cyc("rm");
    check_outputs("rm");
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    req_valid = '0;
    chk("rm:ready", 32'(req_ready), 0);
    chk("rm:active", 32'(gact), 0);
    chk("rm:gid", 32'(gid), 0);
    chk("rm:occ", 32'(occ), 0);
    chk("rm:we", 32'(fwe), 0);
    chk("rm:wdata", 32'(fdin), 0);
    req_valid = 4'b1111;
    cyc("rm");
    chk("rm:regrant0", 32'(gid), 0);
    chk("rm:ready0", 32'(req_ready), 32'h1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom_range(0, 15));
      pop      = ($urandom_range(0, 2) == 0);
      req_data = $urandom;
      cyc("rnd");
    end
    check_outputs("rnd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
